mult_rr_sched: RTL and testbench

//  Round-robin scheduler sharing one pipelined N_MUL_LEN-bit multiplier (mult) among N_REQ requesters.

---
 rtl/mult_rr_sched_if.sv | 26 ++
 rtl/mult_rr_sched.sv | 118 +++++++++++
 tb/tb_mult_rr_sched.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_rr_sched_if.sv
// Requester-side bundle for the shared-multiplier scheduler.
// Carries the operand handshake and the tagged, one-hot response strobe.
interface mult_rr_sched_if #(
  parameter int N_REQ     = 4,
  parameter int N_MUL_LEN = 256
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]                req_valid;
  logic [N_REQ-1:0]                req_ready;
  logic [N_REQ-1:0][N_MUL_LEN-1:0] req_x;
  logic [N_REQ-1:0][N_MUL_LEN-1:0] req_y;
  logic [N_REQ-1:0]                rsp_valid;
  logic [ID_W-1:0]                 rsp_id;
  logic [N_MUL_LEN-1:0]            rsp_z;

  modport master (
    output req_valid, req_x, req_y,
    input  req_ready, rsp_valid, rsp_id, rsp_z
  );

  modport slave (
    input  req_valid, req_x, req_y,
    output req_ready, rsp_valid, rsp_id, rsp_z
  );
endinterface

// File: rtl/mult_rr_sched.sv
// Round-robin scheduler sharing one free-running pipelined multiplier among N_REQ requesters.
// Each issue carries its owner ID down a tag pipeline that lines up with the multiplier latency.
module mult_rr_sched #(
  parameter int N_REQ             = 4,
  parameter int N_MUL_LEN         = 256,
  parameter int N_PIPELINE_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 en,
  mult_rr_sched_if.slave       rq,
  output logic [N_MUL_LEN-1:0] mul_x,
  output logic [N_MUL_LEN-1:0] mul_y,
  input  logic [N_MUL_LEN-1:0] mul_z,
  output logic                 busy
);
  localparam int              ID_W    = $clog2(N_REQ);
  localparam int              LAST    = N_PIPELINE_STAGES;
  localparam logic [ID_W:0]   N_REQ_W = (ID_W+1)'(N_REQ);
  localparam logic [ID_W-1:0] ID_MAX  = ID_W'(N_REQ - 1);

  logic [ID_W-1:0]            ptr_q, ptr_d;
  logic [N_MUL_LEN-1:0]       mul_x_q, mul_x_d;
  logic [N_MUL_LEN-1:0]       mul_y_q, mul_y_d;
  logic [LAST:0]              tag_vld_q, tag_vld_d;
  logic [LAST:0][ID_W-1:0]    tag_id_q, tag_id_d;
  logic [N_REQ-1:0]           rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]            rsp_id_q, rsp_id_d;
  logic [N_MUL_LEN-1:0]       rsp_z_q, rsp_z_d;

  logic [N_REQ-1:0]           grant_s;
  logic [ID_W-1:0]            gnt_id_s;
  logic                       found_s;
  logic                       hit_s;
  logic                       accept_s;
  logic [ID_W:0]              sum_s;
  logic [ID_W-1:0]            idx_s;

  // Search requesters starting at the pointer; the first valid one wins
  always_comb begin
    grant_s  = '0;
    gnt_id_s = '0;
    found_s  = 1'b0;
    hit_s    = 1'b0;
    sum_s    = '0;
    idx_s    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum_s          = {1'b0, ptr_q} + (ID_W+1)'(k);
      idx_s          = (sum_s >= N_REQ_W) ? ID_W'(sum_s - N_REQ_W) : ID_W'(sum_s);
      hit_s          = ~found_s & rq.req_valid[idx_s];
      grant_s[idx_s] = hit_s;
      gnt_id_s       = hit_s ? idx_s : gnt_id_s;
      found_s        = found_s | hit_s;
    end
  end

  // Next state: pointer advance, operand issue, tag shift and response capture
  always_comb begin
    accept_s  = en & found_s;
    ptr_d     = ptr_q;
    mul_x_d   = mul_x_q;
    mul_y_d   = mul_y_q;
    if (accept_s) begin
      ptr_d   = (gnt_id_s == ID_MAX) ? '0 : gnt_id_s + ID_W'(1);
      mul_x_d = rq.req_x[gnt_id_s];
      mul_y_d = rq.req_y[gnt_id_s];
    end else begin
      ptr_d   = ptr_q;
      mul_x_d = mul_x_q;
      mul_y_d = mul_y_q;
    end

    tag_vld_d = {tag_vld_q[LAST-1:0], accept_s};
    tag_id_d  = {tag_id_q[LAST-1:0], gnt_id_s};

    // The oldest tag lines up with the product now present on mul_z
    if (tag_vld_q[LAST]) begin
      rsp_valid_d = N_REQ'(1) << tag_id_q[LAST];
      rsp_id_d    = tag_id_q[LAST];
      rsp_z_d     = mul_z;
    end else begin
      rsp_valid_d = '0;
      rsp_id_d    = rsp_id_q;
      rsp_z_d     = rsp_z_q;
    end
  end

  // State registers; reset drops every in-flight tag so no late responses appear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q       <= '0;
      mul_x_q     <= '0;
      mul_y_q     <= '0;
      tag_vld_q   <= '0;
      tag_id_q    <= '0;
      rsp_valid_q <= '0;
      rsp_id_q    <= '0;
      rsp_z_q     <= '0;
    end else begin
      ptr_q       <= ptr_d;
      mul_x_q     <= mul_x_d;
      mul_y_q     <= mul_y_d;
      tag_vld_q   <= tag_vld_d;
      tag_id_q    <= tag_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_z_q     <= rsp_z_d;
    end
  end

  assign rq.req_ready = {N_REQ{en}} & grant_s;
  assign rq.rsp_valid = rsp_valid_q;
  assign rq.rsp_id    = rsp_id_q;
  assign rq.rsp_z     = rsp_z_q;
  assign mul_x        = mul_x_q;
  assign mul_y        = mul_y_q;
  assign busy         = |tag_vld_q;
endmodule

// File: tb/tb_mult_rr_sched.sv
// Directed bench for mult_rr_sched with a two-stage multiplier model and an in-order scoreboard.
// Inputs change just after the rising edge; outputs are sampled 1-2 time units later.
module tb_mult_rr_sched;
  localparam int NR = 4;
  localparam int W  = 256;

  logic         clk = 1'b0;
  logic         rstn;
  logic         en;
  logic [W-1:0] mul_x, mul_y, mul_z;
  logic [W-1:0] mul_s1, mul_s2;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [1:0]   id;
    logic [W-1:0] z;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  int exp_rr [1:11] = '{0, 1, 3, 0, 1, 2, 3, 0, 1, 2, 3};

  mult_rr_sched_if #(.N_REQ(NR), .N_MUL_LEN(W)) rq_if ();

  mult_rr_sched #(.N_REQ(NR), .N_MUL_LEN(W), .N_PIPELINE_STAGES(2)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .en    (en),
    .rq    (rq_if),
    .mul_x (mul_x),
    .mul_y (mul_y),
    .mul_z (mul_z),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Two-stage multiplier: operands visible after edge t give Z after edge t+2
  always @(posedge clk) begin
    mul_s1 <= mul_x * mul_y;
    mul_s2 <= mul_s1;
  end
  assign mul_z = mul_s2;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [1:0] i, input logic [W-1:0] x, input logic [W-1:0] y);
    rq_if.req_x[i] = x;
    rq_if.req_y[i] = y;
  endtask

  task automatic push(input logic [1:0] id);
    exp_t e;
    e.id = id;
    e.z  = rq_if.req_x[id] * rq_if.req_y[id];
    exp_q.push_back(e);
  endtask

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom();
    if ($urandom_range(0, 7) == 0) r = '1;
    return r;
  endfunction

  // Every response strobe must match the oldest outstanding op
  always @(negedge clk) begin
    if (rstn === 1'b1 && rq_if.rsp_valid !== 4'b0000) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", W'(rq_if.rsp_valid), W'(0));
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_rsp_id", W'(rq_if.rsp_id), W'(mon_e.id));
        chk("sb_rsp_onehot", W'(rq_if.rsp_valid), W'(4'b0001 << mon_e.id));
        chk("sb_rsp_z", rq_if.rsp_z, mon_e.z);
      end
    end
  end

  initial begin
    logic [W-1:0] big;
    logic [3:0]   v;
    int           m_ptr, gid, j;
    logic         hit;

    rstn = 1'b0;
    en   = 1'b0;
    rq_if.req_valid = 4'b0000;
    rq_if.req_x = '0;
    rq_if.req_y = '0;
    cyc(2);
    chk("rst_mul_x", mul_x, W'(0));
    chk("rst_mul_y", mul_y, W'(0));
    chk("rst_rsp_valid", W'(rq_if.rsp_valid), W'(0));
    chk("rst_rsp_id", W'(rq_if.rsp_id), W'(0));
    chk("rst_rsp_z", rq_if.rsp_z, W'(0));
    chk("rst_busy", W'(busy), W'(0));
    rstn = 1'b1;
    en   = 1'b1;
    cyc(1);

    // Single op from requester 2
    set_op(2'd2, W'(3), W'(5));
    rq_if.req_valid = 4'b0100;
    #1;
    chk("single_ready", W'(rq_if.req_ready), W'(4'b0100));
    push(2'd2);
    cyc(1);
    rq_if.req_valid = 4'b0000;
    chk("single_busy", W'(busy), W'(1));
    cyc(2);
    chk("single_early", W'(rq_if.rsp_valid), W'(0));
    cyc(1);
    chk("single_valid", W'(rq_if.rsp_valid), W'(4'b0100));
    chk("single_id", W'(rq_if.rsp_id), W'(2));
    chk("single_z", rq_if.rsp_z, W'(15));
    chk("single_busy_low", W'(busy), W'(0));
    cyc(1);
    chk("single_one_cycle", W'(rq_if.rsp_valid), W'(0));
    chk("single_z_hold", rq_if.rsp_z, W'(15));

    // Wrap and skip: pointer sits at 3, only 0 and 1 request
    set_op(2'd0, W'(7), W'(9));
    set_op(2'd1, W'(11), W'(13));
    rq_if.req_valid = 4'b0011;
    #1;
    chk("wrap_gnt0", W'(rq_if.req_ready), W'(4'b0001));
    push(2'd0);
    cyc(1);
    rq_if.req_valid = 4'b0010;
    #1;
    chk("wrap_gnt1", W'(rq_if.req_ready), W'(4'b0010));
    push(2'd1);
    cyc(1);
    set_op(2'd3, W'(17), W'(19));
    set_op(2'd0, W'(21), W'(23));
    set_op(2'd1, W'(25), W'(27));
    rq_if.req_valid = 4'b1011;
    #1;
    chk("wrap_ptr_at_2", W'(rq_if.req_ready), W'(4'b1000));
    push(2'd3);
    cyc(1);

    // Round robin with all four requesting; responses stream back-to-back
    set_op(2'd2, W'(31), W'(33));
    set_op(2'd3, W'(35), W'(37));
    rq_if.req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 12; k++) begin
      if (k < 8) begin
        chk("rr_grant", W'(rq_if.req_ready), W'(4'b0001 << (k % 4)));
        push(2'(k % 4));
      end else begin
        chk("rr_idle_ready", W'(rq_if.req_ready), W'(0));
      end
      if (k >= 1) begin
        chk("rr_rsp_valid", W'(rq_if.rsp_valid), W'(4'b0001 << exp_rr[k]));
        chk("rr_rsp_id", W'(rq_if.rsp_id), W'(exp_rr[k]));
      end
      cyc(1);
      if (k < 8) set_op(2'(k % 4), W'(k * 37 + 5), W'(k * 91 + 3));
      if (k == 7) rq_if.req_valid = 4'b0000;
      #1;
    end
    chk("rr_drained", W'(rq_if.rsp_valid), W'(0));
    chk("rr_busy_low", W'(busy), W'(0));

    // Truncation to the low W bits
    big = '0;
    big[W-1] = 1'b1;
    set_op(2'd0, '1, '1);
    set_op(2'd1, big, W'(2));
    rq_if.req_valid = 4'b0011;
    #1;
    chk("trunc_gnt0", W'(rq_if.req_ready), W'(4'b0001));
    push(2'd0);
    cyc(1);
    rq_if.req_valid = 4'b0010;
    #1;
    chk("trunc_gnt1", W'(rq_if.req_ready), W'(4'b0010));
    push(2'd1);
    cyc(1);
    rq_if.req_valid = 4'b0000;
    cyc(2);
    chk("trunc_ones_z", rq_if.rsp_z, W'(1));
    chk("trunc_ones_id", W'(rq_if.rsp_id), W'(0));
    cyc(1);
    chk("trunc_msb_z", rq_if.rsp_z, W'(0));
    chk("trunc_msb_valid", W'(rq_if.rsp_valid), W'(4'b0010));

    // Drain: two ops issued, then en drops while everyone requests
    set_op(2'd2, W'(41), W'(43));
    rq_if.req_valid = 4'b0100;
    #1;
    chk("drain_gnt2", W'(rq_if.req_ready), W'(4'b0100));
    push(2'd2);
    cyc(1);
    set_op(2'd3, W'(45), W'(47));
    rq_if.req_valid = 4'b1000;
    #1;
    chk("drain_gnt3", W'(rq_if.req_ready), W'(4'b1000));
    push(2'd3);
    cyc(1);
    en = 1'b0;
    set_op(2'd0, W'(51), W'(53));
    set_op(2'd1, W'(55), W'(57));
    set_op(2'd2, W'(59), W'(61));
    rq_if.req_valid = 4'b1111;
    #1;
    chk("drain_ready_off", W'(rq_if.req_ready), W'(0));
    chk("drain_busy", W'(busy), W'(1));
    cyc(1);
    chk("drain_ready_off2", W'(rq_if.req_ready), W'(0));
    chk("drain_no_rsp_yet", W'(rq_if.rsp_valid), W'(0));
    cyc(1);
    chk("drain_rsp2", W'(rq_if.rsp_valid), W'(4'b0100));
    chk("drain_busy_mid", W'(busy), W'(1));
    cyc(1);
    chk("drain_rsp3", W'(rq_if.rsp_valid), W'(4'b1000));
    chk("drain_busy_low", W'(busy), W'(0));
    en = 1'b1;
    #1;
    chk("drain_ptr_held", W'(rq_if.req_ready), W'(4'b0001));

    // Reset with three ops in flight: nothing may come back afterwards
    cyc(3);
    rq_if.req_valid = 4'b0000;
    chk("rstmid_busy", W'(busy), W'(1));
    rstn = 1'b0;
    #1;
    chk("rstmid_mul_x", mul_x, W'(0));
    chk("rstmid_mul_y", mul_y, W'(0));
    chk("rstmid_rsp_valid", W'(rq_if.rsp_valid), W'(0));
    chk("rstmid_rsp_id", W'(rq_if.rsp_id), W'(0));
    chk("rstmid_rsp_z", rq_if.rsp_z, W'(0));
    chk("rstmid_busy_low", W'(busy), W'(0));
    cyc(2);
    rstn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      cyc(1);
      chk("rstmid_no_rsp", W'(rq_if.rsp_valid), W'(0));
      chk("rstmid_idle", W'(busy), W'(0));
    end

    // Random soak against a reference round-robin and the scoreboard
    v = 4'b0000;
    m_ptr = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!v[i] && $urandom_range(0, 2) == 0) begin
          v[i] = 1'b1;
          set_op(2'(i), rnd(), rnd());
        end
      end
      en = ($urandom_range(0, 9) != 0);
      rq_if.req_valid = v;
      #1;
      hit = 1'b0;
      gid = 0;
      for (int k = 0; k < NR; k++) begin
        j = (m_ptr + k) % NR;
        if (!hit && v[j]) begin
          hit = 1'b1;
          gid = j;
        end
      end
      chk("soak_ready", W'(rq_if.req_ready), W'((en && hit) ? (4'b0001 << gid) : 4'b0000));
      if (en && hit) begin
        push(2'(gid));
        v[gid] = 1'b0;
        m_ptr = (gid + 1) % NR;
      end
      cyc(1);
    end
    rq_if.req_valid = 4'b0000;
    cyc(6);
    chk("soak_all_returned", W'(exp_q.size()), W'(0));
    chk("soak_busy_low", W'(busy), W'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
